// File: rtl/hex_digit_driver.sv
// Six-digit seven-segment driver: atomic shadow capture, hex decode, blank/blink/LZ suppression, lamp test.
// Latency: load, lz_en and lamp_test reach the registered outputs one edge after they are sampled; no backpressure, load always accepted.
module hex_digit_driver #(
    parameter int CLK_HZ     = 50000000,
    parameter int BLINK_HZ   = 2,
    parameter int ACTIVE_LOW = 1
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [31:0] hex0_3_word,
    input  logic [15:0] hex4_5_word,
    input  logic        load,
    input  logic        lz_en,
    input  logic        lamp_test,
    output logic [41:0] hex_seg,
    output logic [5:0]  hex_dp,
    output logic        blink_phase
);

    localparam int              HALF    = CLK_HZ / (2 * BLINK_HZ);
    localparam int              CW      = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(HALF - 1);
    localparam logic            POL     = (ACTIVE_LOW != 0);
    localparam logic [47:0]     SHADOW_RST = {6{8'h10}};

    logic [47:0]   r_shadow;
    logic [CW-1:0] r_cnt;
    logic          r_blink_phase;
    logic          r_lz_en;
    logic          r_lamp;
    logic [41:0]   r_seg;
    logic [5:0]    r_dp;

    logic [3:0]    w_val [6];
    logic [5:0]    w_blank;
    logic [5:0]    w_blink;
    logic [5:0]    w_dp_bit;
    logic [5:0]    w_supp;
    logic [41:0]   w_seg;
    logic [5:0]    w_dp;

    // Bit 7 of every byte is reserved; it is captured but never read.
    logic w_unused_rsvd;
    assign w_unused_rsvd = ^{r_shadow[47], r_shadow[39], r_shadow[31],
                             r_shadow[23], r_shadow[15], r_shadow[7]};

    function automatic logic [6:0] f_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Both words land in the same edge so the two digit groups never tear.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_shadow <= SHADOW_RST;
            r_lz_en  <= 1'b0;
            r_lamp   <= 1'b0;
        end else begin
            if (load) begin
                r_shadow <= {hex4_5_word, hex0_3_word};
            end
            r_lz_en <= lz_en;
            r_lamp  <= lamp_test;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_cnt         <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt         <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_cnt         <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < 6; k++) begin
            w_val[k]    = r_shadow[8*k +: 4];
            w_blank[k]  = r_shadow[8*k + 4];
            w_blink[k]  = r_shadow[8*k + 5];
            w_dp_bit[k] = r_shadow[8*k + 6];
        end
    end

    // Walk from the most significant digit down; a zero is only leading
    // while everything above it is dark.
    always_comb begin
        logic above_dark;
        w_supp     = '0;
        above_dark = 1'b1;
        for (int k = 5; k >= 1; k--) begin
            w_supp[k]  = r_lz_en && (w_val[k] == 4'd0) && above_dark;
            above_dark = above_dark && (w_blank[k] || w_supp[k]);
        end
    end

    always_comb begin
        w_seg = '0;
        w_dp  = '0;
        for (int k = 0; k < 6; k++) begin
            if (r_lamp) begin
                w_seg[7*k +: 7] = 7'h7F;
            end else if (w_blank[k] || w_supp[k] || (w_blink[k] && r_blink_phase)) begin
                w_seg[7*k +: 7] = 7'h00;
            end else begin
                w_seg[7*k +: 7] = f_decode(w_val[k]);
            end
            w_dp[k] = r_lamp ||
                      (w_dp_bit[k] && !w_blank[k] && !(w_blink[k] && r_blink_phase));
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_seg <= {42{POL}};
            r_dp  <= {6{POL}};
        end else begin
            r_seg <= w_seg ^ {42{POL}};
            r_dp  <= w_dp ^ {6{POL}};
        end
    end

    assign hex_seg     = r_seg;
    assign hex_dp      = r_dp;
    assign blink_phase = r_blink_phase;

endmodule

// File: tb/tb_hex_digit_driver.sv
// Directed bench for hex_digit_driver with HALF = 4 and active-low outputs.
module tb_hex_digit_driver;

    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic [31:0] hex0_3_word = '0;
    logic [15:0] hex4_5_word = '0;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic        lamp_test = 1'b0;
    logic [41:0] hex_seg;
    logic [5:0]  hex_dp;
    logic        blink_phase;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [41:0] SEG_OFF = 42'h3FFFFFFFFFF;
    localparam logic [5:0]  DP_OFF  = 6'h3F;

    hex_digit_driver #(
        .CLK_HZ    (8),
        .BLINK_HZ  (1),
        .ACTIVE_LOW(1)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .hex0_3_word (hex0_3_word),
        .hex4_5_word (hex4_5_word),
        .load        (load),
        .lz_en       (lz_en),
        .lamp_test   (lamp_test),
        .hex_seg     (hex_seg),
        .hex_dp      (hex_dp),
        .blink_phase (blink_phase)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    // Active-high digit codes (digit 5 first) to the inverted output image.
    function automatic logic [41:0] img(input logic [6:0] s5, input logic [6:0] s4,
                                       input logic [6:0] s3, input logic [6:0] s2,
                                       input logic [6:0] s1, input logic [6:0] s0);
        return ~{s5, s4, s3, s2, s1, s0};
    endfunction

    task automatic test_reset();
        reset_reset = 1'b1;
        repeat (3) tick();
        tests_run++;
        if (hex_seg !== SEG_OFF) begin tests_failed++; $display("FAIL reset_seg: got %h exp %h", hex_seg, SEG_OFF); end
        tests_run++;
        if (hex_dp !== DP_OFF) begin tests_failed++; $display("FAIL reset_dp: got %h exp %h", hex_dp, DP_OFF); end
        tests_run++;
        if (blink_phase !== 1'b0) begin tests_failed++; $display("FAIL reset_phase: got %b exp 0", blink_phase); end
        reset_reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            tests_run++;
            if (hex_seg !== SEG_OFF || hex_dp !== DP_OFF) begin
                tests_failed++;
                $display("FAIL reset_hold cyc %0d: got seg %h dp %h exp seg %h dp %h", i, hex_seg, hex_dp, SEG_OFF, DP_OFF);
            end
        end
    endtask

    task automatic test_load_decode();
        logic [41:0] exp;
        exp = img(7'h71, 7'h77, 7'h4F, 7'h5B, 7'h06, 7'h3F);
        hex0_3_word = 32'h03020100;
        hex4_5_word = 16'h0F0A;
        load = 1'b1;
        tick();
        load = 1'b0;
        tests_run++;
        if (hex_seg !== SEG_OFF) begin tests_failed++; $display("FAIL load_latency: got %h exp %h", hex_seg, SEG_OFF); end
        tick();
        tests_run++;
        if (hex_seg !== exp) begin tests_failed++; $display("FAIL load_seg: got %h exp %h", hex_seg, exp); end
        tests_run++;
        if (hex_seg[6:0] !== 7'h40) begin tests_failed++; $display("FAIL load_digit0: got %h exp 40", hex_seg[6:0]); end
        tests_run++;
        if (hex_dp !== DP_OFF) begin tests_failed++; $display("FAIL load_dp: got %h exp %h", hex_dp, DP_OFF); end
    endtask

    task automatic test_back_to_back();
        logic [41:0] exp_a;
        logic [41:0] exp_b;
        exp_a = img(7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06);
        exp_b = img(7'h7F, 7'h6F, 7'h7C, 7'h39, 7'h5E, 7'h79);
        hex0_3_word = 32'h04030201;
        hex4_5_word = 16'h0605;
        load = 1'b1;
        tick();
        hex0_3_word = 32'h0B0C0D0E;
        hex4_5_word = 16'h0809;
        tick();
        load = 1'b0;
        tests_run++;
        if (hex_seg !== exp_a) begin tests_failed++; $display("FAIL b2b_first: got %h exp %h", hex_seg, exp_a); end
        tick();
        tests_run++;
        if (hex_seg !== exp_b) begin tests_failed++; $display("FAIL b2b_last: got %h exp %h", hex_seg, exp_b); end
        tick();
        tests_run++;
        if (hex_seg !== exp_b) begin tests_failed++; $display("FAIL b2b_hold: got %h exp %h", hex_seg, exp_b); end
    endtask

    task automatic test_reserved();
        logic [41:0] exp;
        exp = img(7'h71, 7'h77, 7'h4F, 7'h5B, 7'h06, 7'h3F);
        hex0_3_word = 32'h83828180;
        hex4_5_word = 16'h8F8A;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tests_run++;
        if (hex_seg !== exp || hex_dp !== DP_OFF) begin
            tests_failed++;
            $display("FAIL reserved_bit7: got seg %h dp %h exp seg %h dp %h", hex_seg, hex_dp, exp, DP_OFF);
        end
    endtask

    task automatic test_lz();
        logic [41:0] exp;
        hex0_3_word = 32'h00010000;
        hex4_5_word = 16'h0000;
        lz_en = 1'b1;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        exp = img(7'h00, 7'h00, 7'h00, 7'h06, 7'h3F, 7'h3F);
        tests_run++;
        if (hex_seg !== exp) begin tests_failed++; $display("FAIL lz_on: got %h exp %h", hex_seg, exp); end
        lz_en = 1'b0;
        tick();
        tests_run++;
        if (hex_seg !== exp) begin tests_failed++; $display("FAIL lz_off_latency: got %h exp %h", hex_seg, exp); end
        tick();
        exp = img(7'h3F, 7'h3F, 7'h3F, 7'h06, 7'h3F, 7'h3F);
        tests_run++;
        if (hex_seg !== exp) begin tests_failed++; $display("FAIL lz_off: got %h exp %h", hex_seg, exp); end

        hex0_3_word = 32'h00000000;
        lz_en = 1'b1;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        exp = img(7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F);
        tests_run++;
        if (hex_seg !== exp) begin tests_failed++; $display("FAIL lz_all_zero: got %h exp %h", hex_seg, exp); end

        hex0_3_word = 32'h07000000;
        hex4_5_word = 16'h1000;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        exp = img(7'h00, 7'h00, 7'h07, 7'h3F, 7'h3F, 7'h3F);
        tests_run++;
        if (hex_seg !== exp) begin tests_failed++; $display("FAIL lz_blank_above: got %h exp %h", hex_seg, exp); end
        lz_en = 1'b0;
        tick();
    endtask

    task automatic test_lamp_dp();
        logic [41:0] exp;
        exp = img(7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h6D);
        hex0_3_word = 32'h10105045;
        hex4_5_word = 16'h1010;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tests_run++;
        if (hex_seg !== exp) begin tests_failed++; $display("FAIL dp_image_seg: got %h exp %h", hex_seg, exp); end
        tests_run++;
        if (hex_dp !== 6'h3E) begin tests_failed++; $display("FAIL dp_image_dp: got %h exp 3e", hex_dp); end
        lamp_test = 1'b1;
        tick();
        tests_run++;
        if (hex_seg !== exp) begin tests_failed++; $display("FAIL lamp_latency: got %h exp %h", hex_seg, exp); end
        tick();
        tests_run++;
        if (hex_seg !== 42'h0 || hex_dp !== 6'h0) begin
            tests_failed++;
            $display("FAIL lamp_on: got seg %h dp %h exp all zero", hex_seg, hex_dp);
        end
        lamp_test = 1'b0;
        tick();
        tests_run++;
        if (hex_seg !== 42'h0) begin tests_failed++; $display("FAIL lamp_release_latency: got %h exp 0", hex_seg); end
        tick();
        tests_run++;
        if (hex_seg !== exp || hex_dp !== 6'h3E) begin
            tests_failed++;
            $display("FAIL lamp_restore: got seg %h dp %h exp seg %h dp 3e", hex_seg, hex_dp, exp);
        end
    endtask

    task automatic test_blink();
        logic        ph_now;
        logic        ph_prev;
        logic [41:0] exp;
        logic [5:0]  exp_dp;
        reset_reset = 1'b1;
        tick();
        tick();
        reset_reset = 1'b0;
        hex0_3_word = 32'h10251060;
        hex4_5_word = 16'h1010;
        load = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            load = 1'b0;
            ph_now = ((k / 4) % 2) == 1;
            tests_run++;
            if (blink_phase !== ph_now) begin
                tests_failed++;
                $display("FAIL blink_phase edge %0d: got %b exp %b", k, blink_phase, ph_now);
            end
            if (k >= 2) begin
                ph_prev = (((k - 1) / 4) % 2) == 1;
                exp    = ph_prev ? img(7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00)
                                 : img(7'h00, 7'h00, 7'h00, 7'h6D, 7'h00, 7'h3F);
                exp_dp = ph_prev ? 6'h3F : 6'h3E;
                tests_run++;
                if (hex_seg !== exp || hex_dp !== exp_dp) begin
                    tests_failed++;
                    $display("FAIL blink_out edge %0d: got seg %h dp %h exp seg %h dp %h", k, hex_seg, hex_dp, exp, exp_dp);
                end
            end
        end
    endtask

    task automatic test_collision();
        logic ph;
        repeat (5) tick();
        hex0_3_word = 32'h01020304;
        hex4_5_word = 16'h0506;
        load = 1'b1;
        reset_reset = 1'b1;
        tick();
        tests_run++;
        if (hex_seg !== SEG_OFF || hex_dp !== DP_OFF || blink_phase !== 1'b0) begin
            tests_failed++;
            $display("FAIL collision_reset: got seg %h dp %h ph %b exp seg %h dp %h ph 0", hex_seg, hex_dp, blink_phase, SEG_OFF, DP_OFF);
        end
        reset_reset = 1'b0;
        load = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            tests_run++;
            if (hex_seg !== SEG_OFF || hex_dp !== DP_OFF) begin
                tests_failed++;
                $display("FAIL collision_shadow edge %0d: got seg %h dp %h exp seg %h dp %h", k, hex_seg, hex_dp, SEG_OFF, DP_OFF);
            end
            ph = ((k / 4) % 2) == 1;
            tests_run++;
            if (blink_phase !== ph) begin
                tests_failed++;
                $display("FAIL collision_phase edge %0d: got %b exp %b", k, blink_phase, ph);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_decode();
        test_back_to_back();
        test_reserved();
        test_lz();
        test_lamp_dp();
        test_blink();
        test_collision();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
